// File: rtl/burst_master_port.sv
// Serial bus master port: arbitrates for the bus, shifts the address out MSB-first,
// then moves DATA_W-bit beats. Supports bursts, device-select timeout with retry, and split reads.
module burst_master_port #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 16,
  parameter int DEV_W     = 4,
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 3,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  output logic                         mode,
  output logic                         wr_bus,
  input  logic                         rd_bus,
  input  logic                         ack,
  output logic                         master_valid,
  input  logic                         slave_ready,
  output logic                         master_ready,
  input  logic                         slave_valid,
  output logic                         breq,
  input  logic                         bgrant,
  input  logic                         split,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic                         m_mode,
  input  logic [$clog2(MAX_BURST)-1:0] m_len,
  input  logic                         m_start,
  input  logic [DATA_W-1:0]            m_wr_data,
  output logic                         m_wr_req,
  output logic [DATA_W-1:0]            m_rd_data,
  output logic                         m_wr_en,
  output logic                         m_busy,
  output logic                         m_done,
  output logic                         m_err
);

  localparam int LEN_W = $clog2(MAX_BURST);
  localparam int MAXW  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAXW + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int RT_W  = $clog2(MAX_RETRY + 2);

  typedef enum logic [3:0] {
    IDLE, REQ, FETCH, DEV, ADDR, WR_DATA, WR_LOAD, RD_DATA, SPLIT, TOUT, DONE, ERR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-2:0]   rdsh_q, rdsh_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                mode_q, mode_d;
  logic                wr_en_q, wr_en_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic [TO_W-1:0]     tout_q, tout_d;
  logic [RT_W-1:0]     retry_q, retry_d;
  logic [DATA_W-1:0]   rd_word;

  assign rd_word      = {rdsh_q, rd_bus};
  assign mode         = mode_q;
  assign m_rd_data    = rd_data_q;
  assign m_wr_en      = wr_en_q;
  assign m_busy       = (state_q != IDLE);
  assign wr_bus       = (state_q == WR_DATA || state_q == WR_LOAD) ? wdata_q[DATA_W-1]
                                                                   : addr_q[ADDR_W-1];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdsh_q    <= '0;
      rd_data_q <= '0;
      mode_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      len_q     <= '0;
      beat_q    <= '0;
      bit_q     <= '0;
      tout_q    <= '0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdsh_q    <= rdsh_d;
      rd_data_q <= rd_data_d;
      mode_q    <= mode_d;
      wr_en_q   <= wr_en_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      bit_q     <= bit_d;
      tout_q    <= tout_d;
      retry_q   <= retry_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdsh_d       = rdsh_q;
    rd_data_d    = rd_data_q;
    mode_d       = mode_q;
    wr_en_d      = 1'b0;
    len_d        = len_q;
    beat_d       = beat_q;
    bit_d        = bit_q;
    tout_d       = tout_q;
    retry_d      = retry_q;
    master_valid = 1'b0;
    master_ready = 1'b0;
    breq         = 1'b0;
    m_wr_req     = 1'b0;
    m_done       = 1'b0;
    m_err        = 1'b0;

    case (state_q)
      IDLE: begin
        if (m_start) state_d = REQ;
      end
      REQ: begin
        breq = 1'b1;
        if (bgrant) state_d = FETCH;
      end
      FETCH: begin
        breq    = 1'b1;
        addr_d  = m_addr;
        mode_d  = m_mode;
        len_d   = m_len;
        wdata_d = m_wr_data;
        bit_d   = '0;
        beat_d  = '0;
        tout_d  = '0;
        state_d = DEV;
      end
      // A completed device-select phase takes priority over a coincident timeout.
      DEV: begin
        breq         = 1'b1;
        master_valid = 1'b1;
        tout_d       = tout_q + TO_W'(1);
        if (slave_ready) begin
          addr_d = addr_q << 1;
          bit_d  = bit_q + CNT_W'(1);
        end
        if (slave_ready && bit_q == CNT_W'(DEV_W - 1)) begin
          state_d = ack ? ADDR : ERR;
        end else if (tout_q == TO_W'(TIMEOUT - 1)) begin
          state_d = TOUT;
          retry_d = retry_q + RT_W'(1);
        end
      end
      ADDR: begin
        breq         = 1'b1;
        master_valid = 1'b1;
        if (slave_ready) begin
          addr_d = addr_q << 1;
          if (bit_q == CNT_W'(ADDR_W - 1)) begin
            bit_d   = '0;
            state_d = mode_q ? WR_DATA : RD_DATA;
          end else begin
            bit_d = bit_q + CNT_W'(1);
          end
        end
      end
      WR_DATA: begin
        breq         = 1'b1;
        master_valid = 1'b1;
        if (slave_ready) begin
          wdata_d = wdata_q << 1;
          if (bit_q == CNT_W'(DATA_W - 1)) begin
            bit_d = '0;
            if (beat_q == len_q) begin
              state_d = DONE;
            end else begin
              m_wr_req = 1'b1;
              beat_d   = beat_q + LEN_W'(1);
              state_d  = WR_LOAD;
            end
          end else begin
            bit_d = bit_q + CNT_W'(1);
          end
        end
      end
      WR_LOAD: begin
        breq    = 1'b1;
        wdata_d = m_wr_data;
        state_d = WR_DATA;
      end
      // split beats slave_valid: the bit on rd_bus is not taken in that cycle.
      RD_DATA: begin
        breq         = 1'b1;
        master_ready = 1'b1;
        if (split) begin
          state_d = SPLIT;
        end else if (slave_valid) begin
          rdsh_d = (DATA_W-1)'(rd_word);
          if (bit_q == CNT_W'(DATA_W - 1)) begin
            rd_data_d = rd_word;
            wr_en_d   = 1'b1;
            bit_d     = '0;
            if (beat_q == len_q) begin
              state_d = DONE;
            end else begin
              beat_d = beat_q + LEN_W'(1);
            end
          end else begin
            bit_d = bit_q + CNT_W'(1);
          end
        end
      end
      SPLIT: begin
        breq = 1'b1;
        if (!split) state_d = RD_DATA;
      end
      TOUT: begin
        state_d = (retry_q <= RT_W'(MAX_RETRY)) ? REQ : ERR;
      end
      DONE: begin
        breq    = 1'b1;
        m_done  = 1'b1;
        retry_d = '0;
        state_d = IDLE;
      end
      ERR: begin
        m_err   = 1'b1;
        retry_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/burst_master_port.md
Name: burst_master_port

Overview:
Parametrised serial bus master port that sits between a local master and the shared serial system bus. It arbitrates for the bus and shifts out the address MSB-first, then transfers DATA_W-bit data beats serially. Compared with the single-beat 8/16-bit port, it adds generic widths, multi-beat bursts, a configurable address-phase timeout with bounded retry, and explicit done/error status to the master.

Parameters:
DATA_W, 8, data beat width in bits
ADDR_W, 16, total address width in bits
DEV_W, 4, leading address bits forming the device-select phase; ack is checked after these bits
TIMEOUT, 64, cycle limit for the device-select phase before abandoning the attempt
MAX_RETRY, 3, number of timeout retries before an error is reported
MAX_BURST, 4, maximum beats per transaction

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset
mode  out  1  latched direction: 1 = write, 0 = read
wr_bus  out  1  serial address/write-data bit, MSB first
rd_bus  in  1  serial read-data bit
ack  in  1  device-select acknowledge from the addressed slave
master_valid  out  1  wr_bus is valid
slave_ready  in  1  slave accepts the wr_bus bit
master_ready  out  1  master accepts the rd_bus bit
slave_valid  in  1  rd_bus is valid
breq  out  1  bus request
bgrant  in  1  bus grant
split  in  1  slave split; the read is suspended
m_addr  in  ADDR_W  transaction start address
m_mode  in  1  1 = write, 0 = read
m_len  in  clog2(MAX_BURST)  beats minus 1
m_start  in  1  start pulse; sampled only in IDLE
m_wr_data  in  DATA_W  write beat data
m_wr_req  out  1  one-cycle pulse: present the next write beat on m_wr_data next cycle
m_rd_data  out  DATA_W  last completed read beat
m_wr_en  out  1  one-cycle strobe: m_rd_data holds a new beat
m_busy  out  1  high in any state except IDLE
m_done  out  1  one-cycle pulse on successful completion
m_err  out  1  one-cycle pulse on nack or retry exhaustion

Behaviour:
- Reset, when rstn is low at a clk edge: state goes to IDLE and all outputs, counters and shift registers go to 0. Reset applied mid-transfer aborts immediately; breq is low the next cycle.
- States and transitions:
  - IDLE: on m_start, go to REQ.
  - REQ: breq=1; on bgrant, go to FETCH.
  - FETCH: latch m_addr, m_mode, m_len and the first m_wr_data; clear the bit count and timeout count; go to DEV.
  - DEV: shift out DEV_W bits.
  - ADDR: shift out the remaining ADDR_W-DEV_W bits.
  - WR_DATA or RD_DATA: transfer the data beats.
  - SPLIT: read suspended.
  - TOUT: bus released for one cycle.
  - DONE or ERR: report status, then return to IDLE.
- A bit is transferred on a cycle with master_valid & slave_ready (address/write) or master_ready & slave_valid (read). A register shifts and the bit counter increments only on a transferred bit.
- master_valid is high in DEV, ADDR and WR_DATA. master_ready is high only in RD_DATA. breq is high in every state except IDLE, TOUT and ERR.
- Device-select phase:
  - ack is sampled in the cycle the DEV_W-th bit transfers. ack=1 goes to ADDR; ack=0 goes to ERR.
  - The timeout counter increments every DEV cycle. On reaching TIMEOUT-1, go to TOUT and increment the retry count.
  - TOUT goes to REQ if retries ≤ MAX_RETRY, otherwise to ERR.
- After the last ADDR bit, go to WR_DATA if mode=1, otherwise RD_DATA. The address is sent once per transaction; the slave auto-increments.
- Write beats:
  - At the end of each DATA_W-bit beat that is not the last, pulse m_wr_req and load m_wr_data in the following cycle.
  - Bit transfer resumes the cycle after the load.
  - After beat m_len+1, go to DONE.
- Read beats:
  - On each completed beat, load m_rd_data and pulse m_wr_en in the same cycle.
  - After beat m_len+1, go to DONE.
- split=1 in RD_DATA goes to SPLIT. In SPLIT, master_ready=0, breq is held and the bit and beat counters are preserved. split=0 returns to RD_DATA and resumes the same bit.
- If split and slave_valid are both high in the same cycle, split wins and no bit is taken.
- DONE pulses m_done; ERR pulses m_err. Both clear the retry count.
- m_start outside IDLE is ignored. A burst never exceeds MAX_BURST beats, since m_len is range-limited by its width.

Test Plan:
- Single-beat write, DATA_W=8, ADDR_W=16, addr 0x5A3C, data 0xC3, slave_ready always 1, ack=1 -> wr_bus carries 0x5A3C then 0xC3 MSB-first; m_done pulses once; breq falls the cycle after DONE.
- 4-beat read, m_len=3, slave returns 0x11,0x22,0x33,0x44 -> exactly four m_wr_en pulses with m_rd_data matching in order; m_done pulses after the 4th.
- Read with split asserted for 10 cycles after bit 3 of beat 2 -> master_ready is low during the split; the beat resumes at bit 4; all data is correct.
- slave_ready held 0 in DEV -> TOUT after 64 cycles; breq drops for 1 cycle; the attempt repeats 3 more times; the 4th timeout raises m_err and the port returns to IDLE.
- ack=0 at the 4th DEV bit -> m_err pulse, no data phase, m_done stays 0.
- rstn held low for one cycle during WR_DATA -> all outputs are 0 the next cycle; a new m_start then completes normally.
